// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the branch predictor: lookup, resolved-branch
// feedback, flush request and statistics.
interface branch_predictor_if #(
  parameter int STAT_W = 32
);
  // Fetch-stage lookup
  logic [31:0]       fetch_pc;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [31:0]       pred_npc;
  // Execute-stage resolution feedback
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_pred_taken;
  logic [31:0]       upd_pred_target;
  // Recovery and performance counters
  logic              mispredict;
  logic [31:0]       recover_pc;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  // Pipeline side: drives PCs and resolution, consumes predictions.
  modport master (
    output fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_taken, pred_target, pred_npc, mispredict, recover_pc,
           stat_branches, stat_mispredicts
  );

  // Predictor side.
  modport slave (
    input  fetch_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_taken, pred_target, pred_npc, mispredict, recover_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor.sv
// Next-PC predictor: direct-mapped BTB with 2-bit saturating direction
// counters, trained by execute-stage resolutions, plus saturating
// branch / mispredict statistics.
module branch_predictor #(
  parameter int         ENTRIES   = 16,
  parameter int         STAT_W    = 32,
  parameter logic [1:0] ALLOC_CTR = 2'b10
) (
  input  logic              CLK,
  input  logic              nRST,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  // Table storage. Only valid and ctr are reset; a stale tag/target is
  // harmless while its valid bit is clear.
  logic             r_valid  [ENTRIES];
  logic [1:0]       r_ctr    [ENTRIES];
  logic [TAG_W-1:0] r_tag    [ENTRIES];
  logic [31:0]      r_target [ENTRIES];

  logic [STAT_W-1:0] r_stat_branches;
  logic [STAT_W-1:0] r_stat_mispredicts;

  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic             w_fetch_hit;
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  logic             w_mispredict;

  assign w_fetch_idx = bp.fetch_pc[IDX_W+1:2];
  assign w_fetch_tag = bp.fetch_pc[31:IDX_W+2];
  assign w_upd_idx   = bp.upd_pc[IDX_W+1:2];
  assign w_upd_tag   = bp.upd_pc[31:IDX_W+2];

  // Lookup reads registered state only, so a same-cycle update is not visible.
  assign w_fetch_hit    = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign bp.pred_taken  = w_fetch_hit & r_ctr[w_fetch_idx][1];
  assign bp.pred_target = w_fetch_hit ? r_target[w_fetch_idx] : 32'd0;
  assign bp.pred_npc    = bp.pred_taken ? bp.pred_target : bp.fetch_pc + 32'd4;

  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  // Wrong direction, or right "taken" direction with the wrong target.
  assign w_mispredict = bp.upd_valid &
                        ((bp.upd_taken != bp.upd_pred_taken) |
                         (bp.upd_taken & bp.upd_pred_taken &
                          (bp.upd_target != bp.upd_pred_target)));
  assign bp.mispredict = w_mispredict;
  assign bp.recover_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + 32'd4;

  assign bp.stat_branches    = r_stat_branches;
  assign bp.stat_mispredicts = r_stat_mispredicts;

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic w_sel;
      assign w_sel = bp.upd_valid && (w_upd_idx == IDX_W'(gi));

      // Direction training: saturate on hits, allocate weakly-taken on taken misses.
      always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
          r_valid[gi] <= 1'b0;
          r_ctr[gi]   <= 2'b00;
        end else if (w_sel) begin
          if (w_upd_hit) begin
            if (bp.upd_taken)
              r_ctr[gi] <= (r_ctr[gi] == 2'b11) ? 2'b11 : r_ctr[gi] + 2'd1;
            else
              r_ctr[gi] <= (r_ctr[gi] == 2'b00) ? 2'b00 : r_ctr[gi] - 2'd1;
          end else if (bp.upd_taken) begin
            r_valid[gi] <= 1'b1;
            r_ctr[gi]   <= ALLOC_CTR;
          end
        end
      end

      // Tag/target written on any taken resolution (hit refreshes target,
      // miss allocates and evicts any alias).
      always_ff @(posedge CLK) begin
        if (w_sel && bp.upd_taken) begin
          r_tag[gi]    <= w_upd_tag;
          r_target[gi] <= bp.upd_target;
        end
      end
    end
  endgenerate

  // Saturating performance counters.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (bp.upd_valid && (r_stat_branches != {STAT_W{1'b1}}))
        r_stat_branches <= r_stat_branches + 1'b1;
      if (w_mispredict && (r_stat_mispredicts != {STAT_W{1'b1}}))
        r_stat_mispredicts <= r_stat_mispredicts + 1'b1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, STAT_W=8).
module tb_branch_predictor;
  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_fail;

  branch_predictor_if #(.STAT_W(8)) bp_if ();

  branch_predictor #(.ENTRIES(16), .STAT_W(8), .ALLOC_CTR(2'b10)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bp   (bp_if.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic ptk, input logic [31:0] ptgt);
    bp_if.upd_valid       = 1'b1;
    bp_if.upd_pc          = pc;
    bp_if.upd_taken       = tk;
    bp_if.upd_target      = tgt;
    bp_if.upd_pred_taken  = ptk;
    bp_if.upd_pred_target = ptgt;
    #1;
  endtask

  task automatic clr_upd();
    bp_if.upd_valid = 1'b0;
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    nRST = 1'b0;
    bp_if.fetch_pc = 32'h40;
    bp_if.upd_valid = 1'b0;
    bp_if.upd_pc = 32'h0;
    bp_if.upd_taken = 1'b0;
    bp_if.upd_target = 32'h0;
    bp_if.upd_pred_taken = 1'b0;
    bp_if.upd_pred_target = 32'h0;

    // Reset state
    #2;
    chk("rst_pred_taken", 32'(bp_if.pred_taken), 32'd0);
    chk("rst_pred_target", bp_if.pred_target, 32'h0);
    chk("rst_pred_npc", bp_if.pred_npc, 32'h44);
    chk("rst_stat_br", 32'(bp_if.stat_branches), 32'd0);
    chk("rst_stat_mp", 32'(bp_if.stat_mispredicts), 32'd0);
    #5 nRST = 1'b1;
    tick();

    // Allocation, mispredict, same-cycle lookup sees old contents
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    chk("alloc_mispredict", 32'(bp_if.mispredict), 32'd1);
    chk("alloc_recover", bp_if.recover_pc, 32'h100);
    chk("same_cycle_pred", 32'(bp_if.pred_taken), 32'd0);
    tick(); clr_upd();
    chk("alloc_pred_taken", 32'(bp_if.pred_taken), 32'd1);
    chk("alloc_pred_npc", bp_if.pred_npc, 32'h100);
    chk("alloc_stat_br", 32'(bp_if.stat_branches), 32'd1);
    chk("alloc_stat_mp", 32'(bp_if.stat_mispredicts), 32'd1);

    // Hysteresis: 10 -> 01
    set_upd(32'h40, 1'b0, 32'h0, 1'b1, 32'h100);
    chk("nt1_mispredict", 32'(bp_if.mispredict), 32'd1);
    chk("nt1_recover", bp_if.recover_pc, 32'h44);
    tick(); clr_upd();
    chk("nt1_pred_npc", bp_if.pred_npc, 32'h44);
    // 01 -> 00 -> 00 (floor)
    set_upd(32'h40, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("nt2_no_mispredict", 32'(bp_if.mispredict), 32'd0);
    tick(); tick(); clr_upd();
    // 00 -> 01, still not taken
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); clr_upd();
    chk("t1_pred_taken", 32'(bp_if.pred_taken), 32'd0);
    chk("t1_pred_target", bp_if.pred_target, 32'h100);
    // 01 -> 10, taken
    set_upd(32'h40, 1'b1, 32'h100, 1'b0, 32'h0);
    tick(); clr_upd();
    chk("t2_pred_taken", 32'(bp_if.pred_taken), 32'd1);
    chk("hyst_stat_br", 32'(bp_if.stat_branches), 32'd6);
    chk("hyst_stat_mp", 32'(bp_if.stat_mispredicts), 32'd4);

    // Target change on a hit
    set_upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h100);
    chk("tgt_mispredict", 32'(bp_if.mispredict), 32'd1);
    chk("tgt_recover", bp_if.recover_pc, 32'h200);
    tick(); clr_upd();
    chk("tgt_pred_npc", bp_if.pred_npc, 32'h200);
    set_upd(32'h40, 1'b1, 32'h200, 1'b1, 32'h200);
    chk("tgt_correct_no_mp", 32'(bp_if.mispredict), 32'd0);
    tick(); clr_upd();

    // Aliasing: 0x80 shares 0x40's index
    bp_if.fetch_pc = 32'h80; #1;
    chk("alias_miss_taken", 32'(bp_if.pred_taken), 32'd0);
    chk("alias_miss_npc", bp_if.pred_npc, 32'h84);
    chk("alias_miss_target", bp_if.pred_target, 32'h0);
    set_upd(32'h80, 1'b1, 32'h300, 1'b0, 32'h0);
    tick(); clr_upd();
    chk("alias_new_npc", bp_if.pred_npc, 32'h300);
    bp_if.fetch_pc = 32'h40; #1;
    chk("alias_evicted_npc", bp_if.pred_npc, 32'h44);

    // Miss, not taken: table untouched
    set_upd(32'hC4, 1'b0, 32'h0, 1'b0, 32'h0);
    chk("mnt_no_mp", 32'(bp_if.mispredict), 32'd0);
    chk("mnt_recover", bp_if.recover_pc, 32'hC8);
    tick(); clr_upd();
    bp_if.fetch_pc = 32'hC4; #1;
    chk("mnt_pred_taken", 32'(bp_if.pred_taken), 32'd0);

    // 32-bit wraparound
    bp_if.fetch_pc = 32'hFFFFFFFC; #1;
    chk("wrap_pred_npc", bp_if.pred_npc, 32'h0);
    set_upd(32'hFFFFFFFC, 1'b0, 32'h0, 1'b1, 32'h500);
    chk("wrap_recover", bp_if.recover_pc, 32'h0);
    tick(); clr_upd();
    chk("pre_sat_stat_br", 32'(bp_if.stat_branches), 32'd11);
    chk("pre_sat_stat_mp", 32'(bp_if.stat_mispredicts), 32'd7);

    // Statistics saturation
    for (int i = 0; i < 300; i++) begin
      set_upd(32'h10, 1'b1, 32'h500, 1'b0, 32'h0);
      tick();
    end
    clr_upd();
    chk("sat_stat_br", 32'(bp_if.stat_branches), 32'hFF);
    chk("sat_stat_mp", 32'(bp_if.stat_mispredicts), 32'hFF);
    bp_if.fetch_pc = 32'h10; #1;
    chk("sat_pred_npc", bp_if.pred_npc, 32'h500);

    // Asynchronous reset mid-update, between clock edges
    set_upd(32'h10, 1'b1, 32'h600, 1'b0, 32'h0);
    nRST = 1'b0; #1;
    chk("arst_pred_taken", 32'(bp_if.pred_taken), 32'd0);
    chk("arst_pred_target", bp_if.pred_target, 32'h0);
    chk("arst_pred_npc", bp_if.pred_npc, 32'h14);
    chk("arst_stat_br", 32'(bp_if.stat_branches), 32'd0);
    chk("arst_stat_mp", 32'(bp_if.stat_mispredicts), 32'd0);
    chk("arst_mispredict", 32'(bp_if.mispredict), 32'd1);
    clr_upd();
    bp_if.fetch_pc = 32'h80; #1;
    chk("arst_alias_entry", 32'(bp_if.pred_taken), 32'd0);
    nRST = 1'b1;
    tick();
    chk("post_rst_npc", bp_if.pred_npc, 32'h84);
    chk("post_rst_stat_br", 32'(bp_if.stat_branches), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Fetch-stage next-PC predictor for the pipelined MIPS core, generalising the single-cycle datapath's fixed PC+4 / branch / jump selection into a parametrised branch target buffer (BTB) with 2-bit saturating direction counters. The fetch stage looks up the current PC combinationally and gets a predicted next PC. The execute stage reports each resolved branch or jump back. The block trains its table on those reports, raises `mispredict` with the recovery PC, and keeps saturating performance counters.

## Interface
Parameters:
- ENTRIES, 16, BTB depth; power of two, ≥ 2; IDX_W = log2(ENTRIES)
- STAT_W, 32, width of each statistics counter
- ALLOC_CTR, 2'b10, counter value written on allocation (weakly taken)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- fetch_pc  in  32  PC currently being fetched
- pred_taken  out  1  BTB hit and counter[1] set
- pred_target  out  32  stored target on hit, else 0
- pred_npc  out  32  pred_taken ? pred_target : fetch_pc + 4
- upd_valid  in  1  a resolved control-flow instruction is in execute this cycle
- upd_pc  in  32  PC of the resolved instruction
- upd_taken  in  1  actual direction (jumps report 1)
- upd_target  in  32  actual target when taken
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction
- upd_pred_target  in  32  predicted target carried down the pipe
- mispredict  out  1  flush request for the stages younger than execute
- recover_pc  out  32  upd_taken ? upd_target : upd_pc + 4
- stat_branches  out  STAT_W  count of upd_valid cycles
- stat_mispredicts  out  STAT_W  count of mispredict cycles

## Operation
- Entry fields: valid, tag = pc[31:IDX_W+2], target[31:0], ctr[1:0]. Index = pc[IDX_W+1:2]; pc[1:0] is ignored.
- Lookup, combinational: hit = valid[idx] & (tag[idx] == fetch_pc tag). pred_taken = hit & ctr[1].
- Misprediction: mispredict = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & upd_target != upd_pred_target)). When upd_valid = 0, mispredict = 0 and recover_pc is don't-care.
- Update on posedge CLK when upd_valid = 1, using upd_pc's index and tag:
  - Hit, taken: ctr saturating-increments (max 2'b11); target <= upd_target.
  - Hit, not taken: ctr saturating-decrements (min 2'b00); target unchanged.
  - Miss, taken: allocate, overwriting any aliased entry. valid <= 1, tag and target written, ctr <= ALLOC_CTR.
  - Miss, not taken: no change to the table.
- Statistics:
  - stat_branches increments on every upd_valid cycle.
  - stat_mispredicts increments on every mispredict cycle.
  - Both saturate at all-ones and never wrap.
- All addition (fetch_pc + 4, upd_pc + 4) is 32-bit modulo. 0xFFFFFFFC + 4 = 0x00000000.

## Timing
- Prediction has zero latency: pred_* depend combinationally on fetch_pc and the registered table only.
- mispredict and recover_pc are combinational in the same cycle as upd_valid.
- Table updates are visible to lookup from the cycle after the update edge.
- Same-cycle lookup and update to the same index: the lookup sees the pre-update contents. There is no bypass.
- Reset (async, any time, including mid-update):
  - all valid bits cleared and all ctr set to 2'b00;
  - stat counters set to 0;
  - tag and target need not be reset.
- Outputs during reset: pred_taken = 0, pred_target = 0, pred_npc = fetch_pc + 4, stat_* = 0. mispredict still follows its combinational definition.
- No internal state besides the table and the stat counters. There is no handshake; upd_valid is a single-cycle qualifier.

## Test plan
- Reset: fetch_pc = 0x40 -> pred_taken = 0, pred_target = 0, pred_npc = 0x44, stat_* = 0.
- Allocation and mispredict:
  - Update upd_pc = 0x40, taken, target 0x100, pred_taken = 0 -> mispredict = 1, recover_pc = 0x100.
  - Next cycle, fetch 0x40 -> pred_taken = 1, pred_npc = 0x100.
  - stat_branches = 1, stat_mispredicts = 1.
- Counter hysteresis at 0x40 (ctr = 10):
  - one not-taken update -> ctr = 01, pred_npc = 0x44;
  - two more not-taken updates -> ctr = 00;
  - one taken update -> ctr = 01, still predicted not-taken;
  - one more taken update -> ctr = 10, predicted taken.
- Target change and aliasing:
  - Hit with upd_pred_target = 0x100, taken to 0x200 -> mispredict = 1, target rewritten to 0x200.
  - With ENTRIES = 16, fetch 0x80 (same index as 0x40) -> miss, pred_npc = 0x84.
  - Taken update at 0x80 evicts 0x40's entry.
- Same-cycle update/lookup: fetch_pc = upd_pc = 0x40, first taken update -> pred_taken = 0 that cycle, 1 the next cycle.
- Saturation and reset:
  - STAT_W = 8, 300 mispredicting updates -> both stat counters = 0xFF.
  - Assert nRST mid-run -> all entries invalid and stats = 0 immediately, without waiting for a clock edge.
